poly_encode12: RTL

// - Serializer for a Kyber polynomial: 12-bit coefficients in, bytes out (ByteEncode_12 / poly_tobytes).
// - It is the inverse direction of the parse/sampling path, which consumes bytes and yields 12-bit coefficients.
// - It sits between NTT/poly arithmetic and the byte stream that feeds the hash/PRF stage or the pk/ct output buffer.
// - Every coefficient pair {d0,d1} becomes 3 bytes: b0=d0[7:0], b1={d1[3:0],d0[11:8]}, b2=d1[11:4].

---
 rtl/poly_encode12.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/poly_encode12.sv
// poly_encode12: serializes a polynomial of 12-bit coefficients into bytes, 3 bytes per pair (ByteEncode_12).
// Optional macro REDUCE_EN: fold each accepted coefficient into [0,Q) with one conditional subtract.
module poly_encode12 #(
    parameter int unsigned N_COEF = 256,
    parameter int unsigned COEF_W = 12
`ifdef REDUCE_EN
    ,
    parameter int unsigned Q      = 3329
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              coef_valid,
    output logic              coef_ready,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned NPAIR = N_COEF / 2;
    localparam int unsigned PC_W  = $clog2(NPAIR) + 1;

    typedef enum logic [2:0] {S_IDLE, S_GET0, S_GET1, S_EMIT, S_FIN} state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pair_cnt_q;
    logic [PC_W-1:0]   pair_cnt_d;
    logic [1:0]        byte_idx_q;
    logic [1:0]        byte_idx_d;
    logic [COEF_W-1:0] d0_q;
    logic [23:0]       hold_q;
    logic              coef_ready_q;
    logic              byte_valid_q;
    logic [7:0]        byte_out_q;
    logic              byte_last_q;
    logic              busy_q;
    logic              done_q;

    logic [COEF_W-1:0] coef_c;
    logic [23:0]       pack_c;
    logic [7:0]        next_byte_c;
    logic              coef_hs_c;
    logic              byte_hs_c;

`ifdef REDUCE_EN
    assign coef_c = (coef_in >= COEF_W'(Q)) ? coef_in - COEF_W'(Q) : coef_in;
`else
    assign coef_c = coef_in;
`endif

    // {b2,b1,b0} with d1 taken straight from the bus on its handshake
    assign pack_c     = {coef_c[11:4], coef_c[3:0], d0_q[11:8], d0_q[7:0]};
    assign coef_hs_c  = coef_valid && coef_ready_q;
    assign byte_hs_c  = byte_valid_q && byte_ready;
    assign pair_cnt_d = pair_cnt_q + PC_W'(1);
    assign byte_idx_d = byte_idx_q + 2'd1;

    always_comb begin
        next_byte_c = hold_q[7:0];
        case (byte_idx_d)
            2'd1:    next_byte_c = hold_q[15:8];
            2'd2:    next_byte_c = hold_q[23:16];
            default: next_byte_c = hold_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pair_cnt_q   <= '0;
            byte_idx_q   <= '0;
            d0_q         <= '0;
            hold_q       <= '0;
            coef_ready_q <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= '0;
            byte_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_GET0;
                        busy_q       <= 1'b1;
                        coef_ready_q <= 1'b1;
                        pair_cnt_q   <= '0;
                        byte_idx_q   <= '0;
                    end
                end
                S_GET0: begin
                    if (coef_hs_c) begin
                        d0_q    <= coef_c;
                        state_q <= S_GET1;
                    end
                end
                S_GET1: begin
                    if (coef_hs_c) begin
                        hold_q       <= pack_c;
                        byte_out_q   <= pack_c[7:0];
                        byte_valid_q <= 1'b1;
                        byte_last_q  <= 1'b0;
                        coef_ready_q <= 1'b0;
                        byte_idx_q   <= '0;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // Output regs only move on a handshake, which gives the hold rule for free
                    if (byte_hs_c) begin
                        if (byte_idx_q != 2'd2) begin
                            byte_idx_q  <= byte_idx_d;
                            byte_out_q  <= next_byte_c;
                            byte_last_q <= (byte_idx_d == 2'd2) && (pair_cnt_q == PC_W'(NPAIR - 1));
                        end else begin
                            byte_idx_q   <= '0;
                            byte_valid_q <= 1'b0;
                            byte_last_q  <= 1'b0;
                            pair_cnt_q   <= pair_cnt_d;
                            if (pair_cnt_d == PC_W'(NPAIR)) begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q      <= S_GET0;
                                coef_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_q     <= 1'b0;
                    pair_cnt_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign coef_ready = coef_ready_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_last  = byte_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
